// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared constants and MEM/WB pipeline register type
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = $clog2(NREG);

    localparam logic [AW-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic            valid;
        logic            isld;
        logic            regwrite;
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] alu;
        logic [XLEN-1:0] ld;
    } mem_wb_t;

endpackage

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - 32x32 architectural register file, one write port, two bypassed read ports
module wb_regfile
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [XLEN-1:0] wdata_i,
    input  logic [AW-1:0]   raddr1_i,
    input  logic [AW-1:0]   raddr2_i,
    output logic [XLEN-1:0] rdata1_o,
    output logic [XLEN-1:0] rdata2_o
);

    logic [XLEN-1:0] rf_q [NREG];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != REG_ZERO)) begin
            rf_q[waddr_i] <= wdata_i;
        end
    end

    // Write-through lets decode see the value committing this cycle.
    function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] addr);
        if (addr == REG_ZERO) begin
            return '0;
        end else if (we_i && (addr == waddr_i)) begin
            return wdata_i;
        end else begin
            return rf_q[addr];
        end
    endfunction

    assign rdata1_o = read_port(raddr1_i);
    assign rdata2_o = read_port(raddr2_i);

endmodule

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - MEM/WB register, writeback mux, register file and retire counters
// Optional load counter output enabled by WB_LOAD_COUNT_EN.
module writeback_stage
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            flush,
    input  logic            mem_valid,
    input  logic            isld,
    input  logic            regwrite,
    input  logic [AW-1:0]   rd,
    input  logic [XLEN-1:0] aluresult1,
    input  logic [XLEN-1:0] ldresult,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            wb_valid,
    output logic            wb_we,
    output logic [AW-1:0]   wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic [31:0]     retire_count
`ifdef WB_LOAD_COUNT_EN
    ,
    output logic [31:0]     load_count
`endif
);

    mem_wb_t     wb_q, wb_d;
    logic [31:0] retire_count_q, retire_count_d;
    logic        retire;

    // Flush only clears valid; the remaining fields are don't-care once invalid.
    always_comb begin
        wb_d = wb_q;
        if (flush) begin
            wb_d.valid = 1'b0;
        end else if (!stall) begin
            wb_d.valid    = mem_valid;
            wb_d.isld     = isld;
            wb_d.regwrite = regwrite;
            wb_d.rd       = rd;
            wb_d.alu      = aluresult1;
            wb_d.ld       = ldresult;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_q <= '0;
        end else begin
            wb_q <= wb_d;
        end
    end

    assign wb_valid = wb_q.valid;
    assign wb_rd    = wb_q.rd;
    assign wb_data  = wb_q.isld ? wb_q.ld : wb_q.alu;
    assign wb_we    = wb_q.valid & wb_q.regwrite & (wb_q.rd != REG_ZERO) & ~stall;

    // Stores and branches retire too, so regwrite does not qualify this.
    assign retire         = wb_q.valid & ~stall;
    assign retire_count_d = retire ? retire_count_q + 32'd1 : retire_count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retire_count_q <= '0;
        end else begin
            retire_count_q <= retire_count_d;
        end
    end

    assign retire_count = retire_count_q;

`ifdef WB_LOAD_COUNT_EN
    logic [31:0] load_count_q, load_count_d;

    assign load_count_d = (retire && wb_q.isld) ? load_count_q + 32'd1 : load_count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_count_q <= '0;
        end else begin
            load_count_q <= load_count_d;
        end
    end

    assign load_count = load_count_q;
`endif

    wb_regfile u_regfile (
        .clk      (clk),
        .reset    (reset),
        .we_i     (wb_we),
        .waddr_i  (wb_q.rd),
        .wdata_i  (wb_data),
        .raddr1_i (rs1_addr),
        .raddr2_i (rs2_addr),
        .rdata1_o (rs1_data),
        .rdata2_o (rs2_data)
    );

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - directed and randomized bench for writeback_stage against a reference model
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        reset, stall, flush, mem_valid, isld, regwrite;
    logic [4:0]  rd, rs1_addr, rs2_addr;
    logic [31:0] aluresult1, ldresult;
    logic [31:0] rs1_data, rs2_data, wb_data, retire_count;
    logic        wb_valid, wb_we;
    logic [4:0]  wb_rd;
`ifdef WB_LOAD_COUNT_EN
    logic [31:0] load_count;
`endif

    always #5 clk = ~clk;

    writeback_stage dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .flush        (flush),
        .mem_valid    (mem_valid),
        .isld         (isld),
        .regwrite     (regwrite),
        .rd           (rd),
        .aluresult1   (aluresult1),
        .ldresult     (ldresult),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .wb_valid     (wb_valid),
        .wb_we        (wb_we),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .retire_count (retire_count)
`ifdef WB_LOAD_COUNT_EN
        ,
        .load_count   (load_count)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: the instruction sitting in WB plus architectural state.
    logic [31:0] m_rf [32];
    bit          m_valid, m_isld, m_rw;
    logic [4:0]  m_rd;
    logic [31:0] m_alu, m_ld, m_ret, m_ldc;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        m_valid = 0; m_isld = 0; m_rw = 0; m_rd = 5'd0;
        m_alu = 32'd0; m_ld = 32'd0; m_ret = 32'd0; m_ldc = 32'd0;
    endtask

    function automatic logic [31:0] m_data();
        return m_isld ? m_ld : m_alu;
    endfunction

    function automatic bit m_commits_write();
        return m_valid && m_rw && (m_rd != 5'd0) && !stall;
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (m_commits_write() && a == m_rd) return m_data();
        return m_rf[a];
    endfunction

    task automatic check_outputs();
        check("wb_valid", wb_valid, m_valid);
        check("wb_we", wb_we, m_commits_write());
        if (m_valid) begin
            check("wb_rd", wb_rd, m_rd);
            check("wb_data", wb_data, m_data());
        end
        check("rs1_data", rs1_data, m_read(rs1_addr));
        check("rs2_data", rs2_data, m_read(rs2_addr));
        check("retire_count", retire_count, m_ret);
`ifdef WB_LOAD_COUNT_EN
        check("load_count", load_count, m_ldc);
`endif
    endtask

    task automatic model_step();
        if (m_commits_write()) m_rf[m_rd] = m_data();
        if (m_valid && !stall) begin
            m_ret = m_ret + 32'd1;
            if (m_isld) m_ldc = m_ldc + 32'd1;
        end
        if (flush) begin
            m_valid = 0;
        end else if (!stall) begin
            m_valid = mem_valid; m_isld = isld; m_rw = regwrite; m_rd = rd;
            m_alu = aluresult1; m_ld = ldresult;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input bit v, input bit l, input bit w, input logic [4:0] r,
                         input logic [31:0] a, input logic [31:0] d);
        mem_valid = v; isld = l; regwrite = w; rd = r; aluresult1 = a; ldresult = d;
    endtask

    task automatic async_reset();
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check("rst_wb_valid", wb_valid, 0);
        check("rst_wb_we", wb_we, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_retire", retire_count, 0);
        for (int a = 0; a < 32; a++) begin
            rs1_addr = 5'(a);
            rs2_addr = 5'(31 - a);
            #1;
            check("rst_rs1", rs1_data, 32'd0);
            check("rst_rs2", rs2_data, 32'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; stall = 0; flush = 0; rs1_addr = 0; rs2_addr = 0;
        drive(0, 0, 0, 5'd0, 32'd0, 32'd0);
        model_reset();
        #1;
        check("reset_wb_valid", wb_valid, 0);
        check("reset_wb_data", wb_data, 0);
        check("reset_retire", retire_count, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // ALU writeback to r5, visible through bypass and then from storage.
        drive(1, 0, 1, 5'd5, 32'h1234, 32'h0);
        cycle();
        drive(0, 0, 0, 5'd0, 32'h0, 32'h0);
        rs1_addr = 5'd5;
        #1;
        check("t1_data", wb_data, 32'h1234);
        check("t1_we", wb_we, 1);
        check("t1_bypass", rs1_data, 32'h1234);
        cycle();
        check("t1_rf", rs1_data, 32'h1234);
        check("t1_retire", retire_count, 32'd1);

        // Load selects ldresult; rs2 bypass in the WB cycle.
        drive(1, 1, 1, 5'd7, 32'h100, 32'hDEADBEEF);
        cycle();
        drive(0, 0, 0, 5'd0, 32'h0, 32'h0);
        rs2_addr = 5'd7;
        #1;
        check("t2_data", wb_data, 32'hDEADBEEF);
        check("t2_bypass", rs2_data, 32'hDEADBEEF);
        cycle();

        // Write to r0 is suppressed but still retires.
        drive(1, 0, 1, 5'd0, 32'hFFFF, 32'h0);
        cycle();
        drive(0, 0, 0, 5'd0, 32'h0, 32'h0);
        rs1_addr = 5'd0;
        #1;
        check("t3_we", wb_we, 0);
        check("t3_r0", rs1_data, 32'd0);
        cycle();
        check("t3_retire", retire_count, 32'd3);

        // Three stalled cycles, then exactly one commit.
        drive(1, 0, 1, 5'd9, 32'hAAAA, 32'h0);
        cycle();
        drive(0, 0, 0, 5'd0, 32'h0, 32'h0);
        stall = 1; rs1_addr = 5'd9;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t4_stall_we", wb_we, 0);
            cycle();
        end
        check("t4_stall_retire", retire_count, 32'd3);
        check("t4_stall_rf", rs1_data, 32'd0);
        stall = 0;
        #1;
        check("t4_we", wb_we, 1);
        cycle();
        check("t4_retire", retire_count, 32'd4);
        check("t4_rf", rs1_data, 32'hAAAA);
        cycle();
        check("t4_once", retire_count, 32'd4);

        // Flush beats stall.
        drive(1, 0, 1, 5'd10, 32'h5555, 32'h0);
        stall = 1; flush = 1;
        cycle();
        drive(0, 0, 0, 5'd0, 32'h0, 32'h0);
        stall = 0; flush = 0; rs1_addr = 5'd10;
        #1;
        check("t5_flush_valid", wb_valid, 0);
        cycle();
        check("t5_flush_rf", rs1_data, 32'd0);
        check("t5_flush_retire", retire_count, 32'd4);

        // Reset while a valid instruction is stalled in WB.
        drive(1, 0, 1, 5'd11, 32'h7777, 32'h0);
        cycle();
        stall = 1;
        drive(0, 0, 0, 5'd0, 32'h0, 32'h0);
        cycle();
        async_reset();
        stall = 0;

        // Counter wrap.
        force dut.retire_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.retire_count_q;
        m_ret = 32'hFFFF_FFFF;
        check("t6_preload", retire_count, 32'hFFFF_FFFF);
        drive(1, 0, 0, 5'd3, 32'h1, 32'h0);
        cycle();
        drive(0, 0, 0, 5'd0, 32'h0, 32'h0);
        cycle();
        check("t6_wrap", retire_count, 32'd0);

`ifdef WB_LOAD_COUNT_EN
        drive(1, 1, 1, 5'd1, 32'h0, 32'h11);
        cycle();
        drive(1, 0, 1, 5'd2, 32'h22, 32'h0);
        cycle();
        drive(1, 1, 0, 5'd3, 32'h0, 32'h33);
        cycle();
        drive(0, 0, 0, 5'd0, 32'h0, 32'h0);
        cycle();
        check("t7_load_count", load_count, 32'd2);
`endif

        for (int n = 0; n < 400; n++) begin
            stall = ($urandom_range(3) == 0);
            flush = ($urandom_range(9) == 0);
            drive($urandom_range(3) != 0, $urandom_range(1) == 1, $urandom_range(3) != 0,
                  5'($urandom), $urandom, $urandom);
            rs1_addr = ($urandom_range(2) == 0) ? m_rd : 5'($urandom);
            rs2_addr = ($urandom_range(2) == 0) ? m_rd : 5'($urandom);
            if ($urandom_range(99) == 0) begin
                async_reset();
            end else begin
                cycle();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final pipeline stage; sits directly downstream of the memory-access stage.
- Holds the MEM/WB pipeline register and selects load data or ALU result as the writeback value.
- Owns the 32x32 architectural register file: one write port, two read ports for decode.
- Counts retired instructions.

Parameters:
- XLEN, 32, datapath width.
- NREG, 32, register count (address width = clog2(NREG) = 5).

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hazard-unit hold; WB register and all state frozen.
- flush  in  1  kill the instruction being captured into WB.
- mem_valid  in  1  MEM stage holds a valid instruction.
- isld  in  1  MEM instruction is a load.
- regwrite  in  1  MEM instruction writes rd.
- rd  in  5  destination register.
- aluresult1  in  XLEN  ALU result from MEM stage.
- ldresult  in  XLEN  load data from MEM stage.
- rs1_addr  in  5  decode read port 1 address.
- rs2_addr  in  5  decode read port 2 address.
- rs1_data  out  XLEN  read port 1 data, combinational.
- rs2_data  out  XLEN  read port 2 data, combinational.
- wb_valid  out  1  WB register holds a valid instruction.
- wb_we  out  1  register-file write occurs this cycle.
- wb_rd  out  5  WB destination register.
- wb_data  out  XLEN  selected writeback value.
- retire_count  out  32  retired-instruction counter.

Behaviour:
- Reset (async, active-high): clears wb_valid and the WB register fields (isld, regwrite, rd, alu, ld) to 0, all register-file entries to 0, and retire_count to 0. Hence every output is 0 during and after reset (read data = 0).
- Capture at each posedge when not in reset:
  - flush=1: wb_valid<=0, other fields don't-care; flush wins over stall.
  - else stall=1: WB register holds.
  - else: wb_valid<=mem_valid; isld, regwrite, rd, aluresult1, ldresult are latched.
- wb_data = wb_isld ? wb_ld : wb_alu. Combinational from the WB register.
- wb_we = wb_valid & wb_regwrite & (wb_rd != 0) & ~stall.
- Register file write: at the posedge ending a cycle with wb_we=1, rf[wb_rd] <= wb_data.
- Retirement: at the posedge ending a cycle with wb_valid=1 and stall=0, retire_count increments.
  - Counts regardless of regwrite, so stores and branches also retire.
  - Wraps from 0xFFFF_FFFF to 0.
- Latency: instruction presented in MEM during cycle N is in WB during cycle N+1; the register file is updated at the end of N+1.
- Read ports, combinational:
  - Address 0 returns 0.
  - If wb_we=1 and rs_addr==wb_rd, returns wb_data (write-through bypass).
  - Otherwise returns rf[rs_addr].
- r0 is hardwired to 0; writes to it are suppressed.
- Stall while WB is valid: no write, no count. The same instruction commits on the first unstalled cycle, exactly once.
- flush never affects the instruction already in WB; it commits normally.
- Reset asserted mid-operation: in-flight WB instruction is discarded, no write occurs, counter returns to 0.

Optional Feature:
- Macro WB_LOAD_COUNT_EN.
- Defined:
  - Adds output load_count, 32 bits, reset 0.
  - Increments on the same retirement condition, additionally qualified by wb_isld=1.
  - Wraps at 2^32.
- Undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package riscv_pkg:
  - XLEN and NREG constants, REG_ZERO = 5'd0.
  - Typedef mem_wb_t: valid, isld, regwrite, rd, alu, ld.
- Natural sub-module wb_regfile contains:
  - the 32x32 storage with async reset;
  - one write port;
  - two combinational read ports with r0 and write-through bypass logic.
- Stage register, mux and counters remain in writeback_stage.

Test Plan:
- Reset, then mem_valid=1, regwrite=1, isld=0, rd=5, aluresult1=0x1234 -> next cycle wb_data=0x1234 and wb_we=1; after that posedge, rs1_addr=5 gives 0x1234 and retire_count=1.
- isld=1, ldresult=0xDEADBEEF, aluresult1=0x100, rd=7 -> wb_data=0xDEADBEEF; in the WB cycle, rs2_addr=7 returns 0xDEADBEEF via bypass.
- regwrite=1, rd=0, aluresult1=0xFFFF -> wb_we=0, rs1_addr=0 reads 0, retire_count still increments.
- Valid instruction in WB, stall=1 for 3 cycles -> no write and retire_count constant; after stall drops, exactly one write and one increment.
- flush=1 and stall=1 together while MEM is valid -> wb_valid=0 next cycle, no write; separately, reset mid-stall -> every register reads 0 and retire_count=0.
- Force retire_count to 0xFFFFFFFF, retire one instruction -> 0. With WB_LOAD_COUNT_EN, retire 2 loads and 1 ALU op -> load_count=2.
